// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one fixed-latency ALU between two requesters.
// Define ALU_ARB_STATS_EN to add the per-requester grant counters gnt_cnt0/gnt_cnt1.
module alu_arbiter #(
    parameter int WIDTH   = 20,
    parameter int OPW     = 3,
    parameter int ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [OPW-1:0]   req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [OPW-1:0]   req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_c,
    output logic             rsp_zero,
    output logic [OPW-1:0]   alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_c,
    input  logic             alu_zero,
`ifdef ALU_ARB_STATS_EN
    output logic [15:0]      gnt_cnt0,
    output logic [15:0]      gnt_cnt1,
`endif
    output logic             busy
);

    localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ALU_LAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0]   rsp_c_q, rsp_c_d;
    logic               rsp_zero_q, rsp_zero_d;
    logic [OPW-1:0]     alu_op_q, alu_op_d;
    logic [WIDTH-1:0]   alu_a_q, alu_a_d;
    logic [WIDTH-1:0]   alu_b_q, alu_b_d;

    logic any_valid;
    logic winner;
    logic grant;

    // On a tie the requester not granted last wins; otherwise the lone valid one wins.
    assign any_valid  = req0_valid | req1_valid;
    assign winner     = (req0_valid & req1_valid) ? ~last_q : req1_valid;
    assign grant      = (state_q == IDLE) & any_valid;
    assign req0_ready = grant & ~winner;
    assign req1_ready = grant & winner;

    always_comb begin
        // NOTE: every _d defaults to its _q first, so no path through the case can infer a latch.
        state_d     = state_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_c_d     = rsp_c_q;
        rsp_zero_d  = rsp_zero_q;
        alu_op_d    = alu_op_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;

        case (state_q)
            IDLE: begin
                if (grant) begin
                    alu_op_d = winner ? req1_op : req0_op;
                    alu_a_d  = winner ? req1_a  : req0_a;
                    alu_b_d  = winner ? req1_b  : req0_b;
                    rsp_id_d = winner;
                    last_d   = winner;
                    cnt_d    = CNT_LOAD;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q == '0) begin
                    rsp_c_d     = alu_c;
                    rsp_zero_d  = alu_zero;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_c_q     <= '0;
            rsp_zero_q  <= 1'b0;
            alu_op_q    <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments make every register update from the same pre-edge values.
            state_q     <= state_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_c_q     <= rsp_c_d;
            rsp_zero_q  <= rsp_zero_d;
            alu_op_q    <= alu_op_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_c     = rsp_c_q;
    assign rsp_zero  = rsp_zero_q;
    assign alu_op    = alu_op_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign busy      = (state_q != IDLE);

`ifdef ALU_ARB_STATS_EN
    logic [15:0] gnt_cnt0_q, gnt_cnt1_q;

    // A ready is only raised towards a valid requester, so ready alone marks a handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_cnt0_q <= '0;
            gnt_cnt1_q <= '0;
        end else begin
            if (req0_ready) gnt_cnt0_q <= gnt_cnt0_q + 16'd1;
            if (req1_ready) gnt_cnt1_q <= gnt_cnt1_q + 16'd1;
        end
    end

    assign gnt_cnt0 = gnt_cnt0_q;
    assign gnt_cnt1 = gnt_cnt1_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: two arbiter instances (ALU_LAT=1 and ALU_LAT=3) driven by randomized
// request traffic and checked against a transaction-level round-robin/ALU reference model.
module tb_alu_arbiter;

    localparam int W    = 20;
    localparam int OPW  = 3;
    localparam int LAT0 = 1;
    localparam int LAT1 = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [1:0]          req0_valid, req1_valid, req0_ready, req1_ready;
    logic [1:0][OPW-1:0] req0_op, req1_op, alu_op;
    logic [1:0][W-1:0]   req0_a, req0_b, req1_a, req1_b;
    logic [1:0]          rsp_valid, rsp_ready, rsp_id, rsp_zero, alu_zero, busy;
    logic [1:0][W-1:0]   rsp_c, alu_a, alu_b, alu_c;
`ifdef ALU_ARB_STATS_EN
    logic [1:0][15:0]    gnt_cnt0, gnt_cnt1;
`endif

    for (genvar g = 0; g < 2; g++) begin : g_dut
        alu_arbiter #(
            .WIDTH  (W),
            .OPW    (OPW),
            .ALU_LAT((g == 0) ? LAT0 : LAT1)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .req0_valid(req0_valid[g]),
            .req0_ready(req0_ready[g]),
            .req0_op   (req0_op[g]),
            .req0_a    (req0_a[g]),
            .req0_b    (req0_b[g]),
            .req1_valid(req1_valid[g]),
            .req1_ready(req1_ready[g]),
            .req1_op   (req1_op[g]),
            .req1_a    (req1_a[g]),
            .req1_b    (req1_b[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_ready (rsp_ready[g]),
            .rsp_id    (rsp_id[g]),
            .rsp_c     (rsp_c[g]),
            .rsp_zero  (rsp_zero[g]),
            .alu_op    (alu_op[g]),
            .alu_a     (alu_a[g]),
            .alu_b     (alu_b[g]),
            .alu_c     (alu_c[g]),
            .alu_zero  (alu_zero[g]),
`ifdef ALU_ARB_STATS_EN
            .gnt_cnt0  (gnt_cnt0[g]),
            .gnt_cnt1  (gnt_cnt1[g]),
`endif
            .busy      (busy[g])
        );
    end

    // Reference model state: pending request per [instance][requester], last grant, grant counts.
    bit             pv  [2][2];
    logic [OPW-1:0] pop [2][2];
    logic [W-1:0]   pa  [2][2];
    logic [W-1:0]   pb  [2][2];
    bit             ref_last [2];
    int unsigned    ref_gnt  [2][2];

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", tag, $time, obs, exp);
        end
    endtask

    // Behavioural ALU used by the bench: NOT, AND, OR, ADD, SUB, XOR, pass-a, pass-b.
    function automatic logic [W-1:0] alu_f(input logic [OPW-1:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        case (op)
            3'd0:    return ~a;
            3'd1:    return a & b;
            3'd2:    return a | b;
            3'd3:    return a + b;
            3'd4:    return a - b;
            3'd5:    return a ^ b;
            3'd6:    return a;
            default: return b;
        endcase
    endfunction

    function automatic logic [W-1:0] rand_val();
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return '1;
            default: return W'($urandom);
        endcase
    endfunction

    task automatic new_req(input int d, input int r);
        pv[d][r]  = 1'b1;
        pop[d][r] = OPW'($urandom);
        pa[d][r]  = rand_val();
        pb[d][r]  = rand_val();
    endtask

    task automatic drive_reqs(input int d);
        req0_valid[d] = pv[d][0];
        req0_op[d]    = pop[d][0];
        req0_a[d]     = pa[d][0];
        req0_b[d]     = pb[d][0];
        req1_valid[d] = pv[d][1];
        req1_op[d]    = pop[d][1];
        req1_a[d]     = pa[d][1];
        req1_b[d]     = pb[d][1];
    endtask

    task automatic alu_garbage(input int d, input logic [W-1:0] c_exp, input logic z_exp);
        alu_c[d]    = c_exp ^ W'($urandom_range(1, (1 << W) - 1));
        alu_zero[d] = ~z_exp;
    endtask

    // One complete transaction on instance d, starting and ending just after a falling edge.
    // mode 0: no new arrivals, 1: random arrivals during the op, 2: the loser arrives during EXEC.
    task automatic run_op(input int d, input int hold, input int mode);
        int             w, lat;
        logic [OPW-1:0] g_op;
        logic [W-1:0]   g_a, g_b, c_exp;
        logic           z_exp;
        lat = (d == 0) ? LAT0 : LAT1;
        rsp_ready[d] = 1'b0;
        drive_reqs(d);
        if (pv[d][0] && pv[d][1]) w = ref_last[d] ? 0 : 1;
        else                      w = pv[d][1] ? 1 : 0;
        #1;
        check("idle_ready0", req0_ready[d], 32'(w == 0));
        check("idle_ready1", req1_ready[d], 32'(w == 1));
        check("idle_busy", busy[d], 0);
        g_op  = pop[d][w];
        g_a   = pa[d][w];
        g_b   = pb[d][w];
        c_exp = alu_f(g_op, g_a, g_b);
        z_exp = (c_exp == '0);

        @(posedge clk);
        ref_last[d] = w[0];
        ref_gnt[d][w]++;
        pv[d][w]  = 1'b0;
        pop[d][w] = OPW'($urandom);
        pa[d][w]  = W'($urandom);
        pb[d][w]  = W'($urandom);
        for (int r = 0; r < 2; r++) begin
            if (!pv[d][r] && ((mode == 1 && $urandom_range(0, 1) == 1) || (mode == 2 && r != w)))
                new_req(d, r);
        end
        @(negedge clk);
        drive_reqs(d);
        #1;
        check("exec_alu_op", 32'(alu_op[d]), 32'(g_op));
        check("exec_alu_a", alu_a[d], g_a);
        check("exec_alu_b", alu_b[d], g_b);
        check("exec_busy", busy[d], 1);
        check("exec_rsp_valid", rsp_valid[d], 0);

        for (int k = 1; k <= lat; k++) begin
            if (k == lat) begin
                alu_c[d]    = c_exp;
                alu_zero[d] = z_exp;
            end else begin
                alu_garbage(d, c_exp, z_exp);
            end
            @(posedge clk);
            @(negedge clk);
            alu_garbage(d, c_exp, z_exp);
            #1;
            check("lat_rsp_valid", rsp_valid[d], 32'(k == lat));
            check("lat_ready_low", {req0_ready[d], req1_ready[d]}, 0);
        end
        check("rsp_id", rsp_id[d], 32'(w));
        check("rsp_c", rsp_c[d], c_exp);
        check("rsp_zero", rsp_zero[d], z_exp);

        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            alu_garbage(d, c_exp, z_exp);
            #1;
            check("hold_rsp_valid", rsp_valid[d], 1);
            check("hold_rsp_id", rsp_id[d], 32'(w));
            check("hold_rsp_c", rsp_c[d], c_exp);
            check("hold_rsp_zero", rsp_zero[d], z_exp);
            check("hold_alu_a", alu_a[d], g_a);
            check("hold_alu_b", alu_b[d], g_b);
            check("hold_no_grant", {req0_ready[d], req1_ready[d]}, 0);
        end

        rsp_ready[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready[d] = 1'b0;
        #1;
        check("done_rsp_valid", rsp_valid[d], 0);
        check("done_busy", busy[d], 0);
    endtask

    task automatic drain(input int d);
        for (int n = 0; n < 4 && (pv[d][0] || pv[d][1]); n++) run_op(d, 0, 0);
    endtask

    task automatic check_reset_outputs(input int d);
        check("rst_rsp_valid", rsp_valid[d], 0);
        check("rst_rsp_id", rsp_id[d], 0);
        check("rst_rsp_c", rsp_c[d], 0);
        check("rst_rsp_zero", rsp_zero[d], 0);
        check("rst_alu_op", 32'(alu_op[d]), 0);
        check("rst_alu_a", alu_a[d], 0);
        check("rst_alu_b", alu_b[d], 0);
        check("rst_busy", busy[d], 0);
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            ref_last[d] = 1'b1;
            for (int r = 0; r < 2; r++) begin
                pv[d][r]      = 1'b0;
                ref_gnt[d][r] = 0;
            end
            drive_reqs(d);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            for (int r = 0; r < 2; r++) begin
                pop[d][r] = '0;
                pa[d][r]  = '0;
                pb[d][r]  = '0;
            end
            rsp_ready[d] = 1'b0;
            alu_c[d]     = '0;
            alu_zero[d]  = 1'b0;
        end
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check_reset_outputs(d);
            check("rst_ready", {req0_ready[d], req1_ready[d]}, 0);
        end

        // NOT of zero on the single-cycle ALU.
        pv[0][0] = 1'b1; pop[0][0] = 3'd0; pa[0][0] = '0; pb[0][0] = 20'h12345;
        run_op(0, 0, 0);

        // Both requesters held valid: grants must alternate.
        for (int d = 0; d < 2; d++) begin
            new_req(d, 0);
            new_req(d, 1);
            for (int i = 0; i < 4; i++) begin
                run_op(d, 0, 0);
                if (!pv[d][0]) new_req(d, 0);
                if (!pv[d][1]) new_req(d, 1);
            end
            drain(d);
        end

        // req1 NOT of all-ones under 5 cycles of back-pressure, with req0 arriving meanwhile.
        for (int d = 0; d < 2; d++) begin
            pv[d][1] = 1'b1; pop[d][1] = 3'd0; pa[d][1] = 20'hFFFFF; pb[d][1] = '0;
            run_op(d, 5, 2);
            drain(d);
        end

        // Randomized traffic with random back-pressure and arrivals.
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 40; i++) begin
                if (!pv[d][0] && !pv[d][1]) new_req(d, $urandom_range(0, 1));
                run_op(d, $urandom_range(0, 3), 1);
            end
            drain(d);
        end

`ifdef ALU_ARB_STATS_EN
        for (int d = 0; d < 2; d++) begin
            check("gnt_cnt0", gnt_cnt0[d], 32'(ref_gnt[d][0] & 32'hFFFF));
            check("gnt_cnt1", gnt_cnt1[d], 32'(ref_gnt[d][1] & 32'hFFFF));
        end
`endif

        // Asynchronous reset in the middle of EXEC on the 3-cycle instance aborts the op.
        new_req(1, 1);
        drive_reqs(1);
        @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_outputs(1);
        check_reset_outputs(0);
`ifdef ALU_ARB_STATS_EN
        check("rst_gnt_cnt0", gnt_cnt0[1], 0);
        check("rst_gnt_cnt1", gnt_cnt1[1], 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check("abort_no_rsp", rsp_valid[1], 0);
            check("abort_idle", busy[1], 0);
        end
        new_req(1, 0);
        new_req(1, 1);
        run_op(1, 0, 0);
        drain(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

endmodule
